// File: rtl/core_periph_bridge.sv
// Memory-stage bridge: turns a held peripheral-access request from the hazard
// unit into one req/ack transaction on the peripheral bus, with timeout.
module core_periph_bridge #(
    parameter logic [63:0] PERIPHERAL_BASE = 64'h2000_0000,
    parameter int          P_ADDR_W        = 16,
    parameter int          TIMEOUT         = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                d_valid,
    input  logic [63:0]         d_addr,
    input  logic                d_write,
    input  logic [63:0]         d_wdata,
    input  logic [7:0]          d_be,
    output logic                d_ready,
    output logic [63:0]         d_rdata,
    output logic                d_err,
    output logic                p_req,
    output logic                p_we,
    output logic [P_ADDR_W-1:0] p_addr,
    output logic [63:0]         p_wdata,
    output logic [7:0]          p_be,
    input  logic                p_ack,
    input  logic [63:0]         p_rdata,
    input  logic                p_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] counter;
    logic       aborted;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            counter <= '0;
            aborted <= 1'b0;
            d_ready <= 1'b0;
            d_rdata <= '0;
            d_err   <= 1'b0;
            p_req   <= 1'b0;
            p_we    <= 1'b0;
            p_addr  <= '0;
            p_wdata <= '0;
            p_be    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    d_ready <= 1'b0;
                    if (d_valid) begin
                        // Subtract at full width, then keep only the low peripheral bits.
                        p_addr  <= P_ADDR_W'(d_addr - PERIPHERAL_BASE);
                        p_we    <= d_write;
                        p_wdata <= d_wdata;
                        p_be    <= d_be;
                        p_req   <= 1'b1;
                        counter <= '0;
                        aborted <= 1'b0;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    counter <= counter + 8'd1;
                    if (!d_valid) begin
                        aborted <= 1'b1;
                    end
                    // An ack arriving on the timeout cycle still wins.
                    if (p_ack) begin
                        d_rdata <= p_we ? 64'd0 : p_rdata;
                        d_err   <= p_err;
                        p_req   <= 1'b0;
                        p_we    <= 1'b0;
                        d_ready <= d_valid && !aborted;
                        state   <= RESP;
                    end else if (counter == TIMEOUT_LAST) begin
                        d_rdata <= {64{1'b1}};
                        d_err   <= 1'b1;
                        p_req   <= 1'b0;
                        d_ready <= d_valid && !aborted;
                        state   <= RESP;
                    end
                end
                RESP: begin
                    d_ready <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    d_ready <= 1'b0;
                    p_req   <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
